// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the phase controller and its environment
// (time base, maintenance request, compare block, lamp drivers, display).
interface traffic_phase_ctrl_if #(
    parameter int size = 8
);
    logic            tick;
    logic            en;
    logic            flash;
    logic            equal;
    logic [size-1:0] cnt;
    logic            sel;
    logic [2:0]      ns_light;
    logic [2:0]      ew_light;
    logic [size-1:0] remain;
    logic            phase_done;
    logic            err;

    // master: the phase controller itself
    modport master (
        input  tick, en, flash, equal,
        output cnt, sel, ns_light, ew_light, remain, phase_done, err
    );

    // slave: time base, compare block, lamps and display
    modport slave (
        output tick, en, flash, equal,
        input  cnt, sel, ns_light, ew_light, remain, phase_done, err
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Four-phase traffic light sequencer with tick timer, flashing-yellow
// maintenance mode, overflow fail-safe and remaining-time output.
module traffic_phase_ctrl #(
    parameter int size   = 8,
    parameter int GREEN  = 30,
    parameter int YELLOW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        EW_G  = 3'd2,
        EW_Y  = 3'd3,
        FLASH = 3'd4
    } state_t;

    localparam logic [size-1:0] one_w    = {{(size-1){1'b0}}, 1'b1};
    localparam logic [size-1:0] green_w  = size'(GREEN);
    localparam logic [size-1:0] yellow_w = size'(YELLOW);

    state_t          state_reg, state_next, adv_state;
    logic [size-1:0] cnt_reg, cnt_next;
    logic            blink_reg, blink_next;
    logic            err_reg, err_next;
    logic            phase_done_reg, phase_done_next;
    logic [size-1:0] target;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= NS_G;
            cnt_reg        <= one_w;
            blink_reg      <= 1'b0;
            err_reg        <= 1'b0;
            phase_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            blink_reg      <= blink_next;
            err_reg        <= err_next;
            phase_done_reg <= phase_done_next;
        end
    end

    always_comb begin
        adv_state = NS_G;
        case (state_reg)
            NS_G:    adv_state = NS_Y;
            NS_Y:    adv_state = EW_G;
            EW_G:    adv_state = EW_Y;
            EW_Y:    adv_state = NS_G;
            default: adv_state = NS_G;
        endcase
    end

    // Next-state logic; en=0 freezes everything, flash outranks tick/equal
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        blink_next      = blink_reg;
        err_next        = err_reg;
        phase_done_next = 1'b0;
        if (bus.en) begin
            if (state_reg == FLASH) begin
                if (!bus.flash) begin
                    state_next      = NS_G;
                    cnt_next        = one_w;
                    blink_next      = 1'b0;
                    phase_done_next = 1'b1;
                end else if (bus.tick) begin
                    blink_next = ~blink_reg;
                    cnt_next   = one_w;
                end
            end else if (bus.flash) begin
                state_next      = FLASH;
                cnt_next        = one_w;
                blink_next      = 1'b1;
                phase_done_next = 1'b1;
            end else if (bus.tick) begin
                if (bus.equal) begin
                    state_next      = adv_state;
                    cnt_next        = one_w;
                    phase_done_next = 1'b1;
                end else if (&cnt_reg) begin
                    // compare never matched: force the phase on and latch the fault
                    state_next      = adv_state;
                    cnt_next        = one_w;
                    err_next        = 1'b1;
                    phase_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + one_w;
                end
            end
        end
    end

    // Moore output decode
    always_comb begin
        bus.sel      = 1'b0;
        bus.ns_light = 3'b001;
        bus.ew_light = 3'b100;
        target       = green_w;
        bus.remain   = '0;
        case (state_reg)
            NS_G: begin
                bus.sel = 1'b0; bus.ns_light = 3'b001; bus.ew_light = 3'b100;
            end
            NS_Y: begin
                bus.sel = 1'b1; bus.ns_light = 3'b010; bus.ew_light = 3'b100;
            end
            EW_G: begin
                bus.sel = 1'b0; bus.ns_light = 3'b100; bus.ew_light = 3'b001;
            end
            EW_Y: begin
                bus.sel = 1'b1; bus.ns_light = 3'b100; bus.ew_light = 3'b010;
            end
            default: begin
                bus.sel      = 1'b1;
                bus.ns_light = blink_reg ? 3'b010 : 3'b000;
                bus.ew_light = blink_reg ? 3'b010 : 3'b000;
            end
        endcase
        target = bus.sel ? yellow_w : green_w;
        // saturate instead of wrapping when the counter has run past the target
        if (state_reg != FLASH && cnt_reg <= target)
            bus.remain = target - cnt_reg + one_w;
    end

    assign bus.cnt        = cnt_reg;
    assign bus.err        = err_reg;
    assign bus.phase_done = phase_done_reg;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a default instance driven by an ideal
// compare model, and a 4-bit instance with equal tied low for the fail-safe.
module tb_traffic_phase_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    traffic_phase_ctrl_if #(.size(8)) bus ();
    traffic_phase_ctrl_if #(.size(4)) bus2 ();

    traffic_phase_ctrl #(.size(8), .GREEN(30), .YELLOW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    traffic_phase_ctrl #(.size(4), .GREEN(10), .YELLOW(3)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ideal compare block for the main instance; the small one never matches
    assign bus.equal  = bus.sel ? (bus.cnt == 8'd3) : (bus.cnt == 8'd30);
    assign bus2.equal = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       en;
        logic       flash;
        logic [7:0] cnt;
        logic       sel;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [7:0] rem;
        logic       pd;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] main_pack();
        return {bus.cnt, bus.remain, bus.ns_light, bus.ew_light, bus.phase_done, bus.sel};
    endfunction

    initial begin
        int         ph_cnt;
        logic [2:0] e_ns, e_ew;
        logic       e_sel, e_pd;
        logic [7:0] e_rem;
        int         ticks;
        bit         done;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.tick = 1'b0;  bus.en = 1'b0;  bus.flash = 1'b0;
        bus2.tick = 1'b0; bus2.en = 1'b0; bus2.flash = 1'b0;

        // NS_G 1 ... NS_G 5, FLASH entry/blink/exit, en=0 masking flash
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 3'b001, 3'b100, 8'd29, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 3'b001, 3'b100, 8'd28, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 3'b001, 3'b100, 8'd27, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 3'b001, 3'b100, 8'd26, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 3'b010, 3'b010, 8'd0,  1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b010, 3'b010, 8'd0,  1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b010, 3'b010, 8'd0,  1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 3'b010, 3'b010, 8'd0,  1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 3'b001, 3'b100, 8'd30, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 3'b001, 3'b100, 8'd30, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 3'b001, 3'b100, 8'd30, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 3'b001, 3'b100, 8'd30, 1'b0};

        // Reset values
        step();
        step();
        chk("reset_main", {8'd0, main_pack()}, {8'd0, 8'd1, 8'd30, 3'b001, 3'b100, 1'b0, 1'b0});
        chk("reset_err", {31'd0, bus.err}, 32'd0);
        $display("reset: cnt=%0d remain=%0d ns=%b ew=%b", bus.cnt, bus.remain, bus.ns_light, bus.ew_light);

        // Full cycle with tick every cycle
        rst_n    = 1'b1;
        bus.en   = 1'b1;
        bus.tick = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            step();
            if (k < 30)      begin ph_cnt = k + 1;  e_ns = 3'b001; e_ew = 3'b100; e_sel = 1'b0; end
            else if (k < 33) begin ph_cnt = k - 29; e_ns = 3'b010; e_ew = 3'b100; e_sel = 1'b1; end
            else if (k < 63) begin ph_cnt = k - 32; e_ns = 3'b100; e_ew = 3'b001; e_sel = 1'b0; end
            else if (k < 66) begin ph_cnt = k - 62; e_ns = 3'b100; e_ew = 3'b010; e_sel = 1'b1; end
            else             begin ph_cnt = 1;      e_ns = 3'b001; e_ew = 3'b100; e_sel = 1'b0; end
            e_pd  = (k == 30) || (k == 33) || (k == 63) || (k == 66);
            e_rem = 8'((e_sel ? 3 : 30) - ph_cnt + 1);
            chk($sformatf("cycle%0d", k), {8'd0, main_pack()},
                {8'd0, 8'(ph_cnt), e_rem, e_ns, e_ew, e_pd, e_sel});
            if (e_pd)
                $display("cycle %0d: phase change ns=%b ew=%b", k, bus.ns_light, bus.ew_light);
        end

        // Slow tick with an en=0 window at cnt=12
        for (int i = 0; i < 44; i++) begin
            bus.tick = (i % 4 == 0);
            step();
        end
        chk("slow_cnt12", {24'd0, bus.cnt}, 32'd12);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.tick = (i % 4 == 0);
            step();
            chk("en_low_hold", {21'd0, bus.cnt, bus.ns_light}, {21'd0, 8'd12, 3'b001});
        end
        bus.en = 1'b1;
        ticks  = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            bus.tick = (i % 4 == 0);
            if (bus.tick) ticks++;
            step();
            if (bus.phase_done) done = 1'b1;
        end
        chk("slow_done_seen", {31'd0, done}, 32'd1);
        chk("slow_ticks_after_en", 32'(ticks), 32'd19);
        chk("slow_in_ns_y", {29'd0, bus.ns_light}, {29'd0, 3'b010});
        $display("en window: %0d ticks after re-enable to NS_Y", ticks);

        // Table-driven flash sequence from a fresh NS_G
        bus.tick  = 1'b0;
        bus.flash = 1'b0;
        do_reset();
        for (int r = 0; r < 15; r++) begin
            bus.tick  = tbl[r].tick;
            bus.en    = tbl[r].en;
            bus.flash = tbl[r].flash;
            step();
            chk($sformatf("row%0d", r), {8'd0, main_pack()},
                {8'd0, tbl[r].cnt, tbl[r].rem, tbl[r].ns, tbl[r].ew, tbl[r].pd, tbl[r].sel});
            $display("row %0d: cnt=%0d ns=%b ew=%b remain=%0d pd=%b",
                     r, bus.cnt, bus.ns_light, bus.ew_light, bus.remain, bus.phase_done);
        end

        // flash on the same edge as tick+equal in NS_Y
        bus.en   = 1'b1;
        bus.tick = 1'b1;
        repeat (32) step();
        chk("nsy_at_cnt3", {23'd0, bus.cnt, bus.sel}, {23'd0, 8'd3, 1'b1});
        chk("nsy_equal", {31'd0, bus.equal}, 32'd1);
        bus.flash = 1'b1;
        step();
        chk("flash_beats_equal", {24'd0, bus.ns_light, bus.ew_light, bus.phase_done, bus.sel},
            {24'd0, 3'b010, 3'b010, 1'b1, 1'b1});
        bus.flash = 1'b0;
        bus.tick  = 1'b0;
        step();
        chk("flash_exit", {21'd0, bus.cnt, bus.ns_light}, {21'd0, 8'd1, 3'b001});
        $display("flash over NS_Y: exit to ns=%b cnt=%0d", bus.ns_light, bus.cnt);

        // Overflow fail-safe on the 4-bit instance
        bus2.en   = 1'b1;
        bus2.tick = 1'b1;
        repeat (14) step();
        chk("ovf_cnt15", {24'd0, bus2.cnt, bus2.remain}, {24'd0, 4'd15, 4'd0});
        chk("ovf_err_before", {31'd0, bus2.err}, 32'd0);
        step();
        chk("ovf_force", {20'd0, bus2.cnt, bus2.remain, bus2.ns_light, bus2.sel},
            {20'd0, 4'd1, 4'd3, 3'b010, 1'b1});
        chk("ovf_err_pd", {30'd0, bus2.err, bus2.phase_done}, {30'd0, 2'b11});
        repeat (15) step();
        chk("ovf_err_sticky", {25'd0, bus2.ns_light, bus2.ew_light, bus2.err},
            {25'd0, 3'b100, 3'b001, 1'b1});
        $display("overflow: err=%b ns=%b ew=%b", bus2.err, bus2.ns_light, bus2.ew_light);

        // Asynchronous reset in the middle of EW_Y
        bus.tick = 1'b0;
        do_reset();
        bus.tick = 1'b1;
        repeat (63) step();
        chk("pre_reset_ew_y", {26'd0, bus.ew_light, bus.ns_light}, {26'd0, 3'b010, 3'b100});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {8'd0, main_pack()}, {8'd0, 8'd1, 8'd30, 3'b001, 3'b100, 1'b0, 1'b0});
        chk("async_reset_err2", {31'd0, bus2.err}, 32'd0);
        $display("async reset: cnt=%0d ns=%b ew=%b", bus.cnt, bus.ns_light, bus.ew_light);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_first", {21'd0, bus.cnt, bus.ns_light}, {21'd0, 8'd2, 3'b001});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase sequencer and timer for the two-road traffic light. Drives the `compare` block's counter value (`cnt`) and duration select (`sel`), consumes its `equal` flag, and steps the junction through its four phases: NS green, NS yellow, EW green, EW yellow. Red on one road always lasts for the other road's green plus yellow. The block also provides a flashing-yellow maintenance mode, a fail-safe on counter overflow, and a remaining-time output for the display.

## Interface
- `size`, 8: counter width; must match the `compare` instance.
- `GREEN`, 30: green duration in ticks; must match the `compare` instance; used only for `remain`.
- `YELLOW`, 3: yellow duration in ticks; must match the `compare` instance; used only for `remain`.

Ports:
- `clk`  in  1  single system clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle time-base strobe (1 Hz in the system).
- `en`  in  1  run enable; 0 freezes all state and ignores `tick`.
- `flash`  in  1  maintenance request; level-sensitive.
- `equal`  in  1  from `compare`; combinational on `cnt` and `sel`.
- `cnt`  out  size  phase tick counter to `compare.A`.
- `sel`  out  1  to `compare.select`; 0 means compare against GREEN, 1 means compare against YELLOW.
- `ns_light`  out  3  {red, yellow, green} for the north-south road; one-hot or 000.
- `ew_light`  out  3  {red, yellow, green} for the east-west road.
- `remain`  out  size  ticks left in the current green or yellow phase.
- `phase_done`  out  1  one-cycle pulse on every phase transition.
- `err`  out  1  sticky overflow flag.

## Operation
- States: NS_G, NS_Y, EW_G, EW_Y, FLASH. Normal cycle is NS_G→NS_Y→EW_G→EW_Y→NS_G.
- Outputs are Moore-decoded from the state register:
  - NS_G: `sel`=0, `ns_light`=001, `ew_light`=100.
  - NS_Y: `sel`=1, `ns_light`=010, `ew_light`=100.
  - EW_G: `sel`=0, `ns_light`=100, `ew_light`=001.
  - EW_Y: `sel`=1, `ns_light`=100, `ew_light`=010.
  - FLASH: `sel`=1; both light outputs are 010 when the blink register is 1, 000 otherwise.
- Advance condition is `en`=1 and `tick`=1 on a rising edge.
- On an advance in a normal state:
  - If `equal`=1: go to the next state, load `cnt`=1, pulse `phase_done`.
  - Else if `cnt` is all-ones: go to the next state, load `cnt`=1, set `err`=1, pulse `phase_done`. This is the fail-safe for a mismatched `compare` configuration.
  - Otherwise: `cnt` increments by 1.
- Phase length: every phase is entered with `cnt`=1, so a phase lasts exactly GREEN or YELLOW advances.
- `remain` = (`sel` ? YELLOW : GREEN) − `cnt` + 1, computed at width `size`. It is 0 in FLASH. If `cnt` exceeds the target, `remain` saturates at 0 and never wraps.
- FLASH entry:
  - `flash`=1 while `en`=1 enters FLASH at the next rising edge, regardless of `tick`.
  - Entry loads `cnt`=1, sets blink=1 and pulses `phase_done`.
- Inside FLASH: blink toggles on each advance; `cnt` holds at 1.
- FLASH exit: when `flash`=0 is sampled in FLASH, go to NS_G with `cnt`=1 and pulse `phase_done`. Exit does not wait for `tick`.
- Priority: `flash` beats `tick`/`equal` on the same edge; `en`=0 beats everything except reset.
- `err` clears only on reset.

## Timing
- Reset values while `rst_n`=0, asynchronous:
  - state=NS_G, `cnt`=1, `sel`=0, `ns_light`=001, `ew_light`=100.
  - `remain`=GREEN, `phase_done`=0, `err`=0, blink=0.
- Reset asserted mid-phase forces these values immediately, with no clock edge needed. The first edge after release behaves as a normal NS_G cycle.
- `equal` is sampled on the same edge it is valid. Round trip `cnt`→`compare`→`equal` is purely combinational, so `compare` adds no cycles.
- State change, `cnt` reload, light change and the `phase_done` pulse all take effect at the same edge. Lights never show an intermediate state.
- `phase_done` is registered; it is high for exactly the one cycle after the transition edge.
- `tick` asserted for several consecutive cycles counts one advance per cycle.

## Test plan
- Defaults, `tick` every cycle, `en`=1, ideal `compare` model. NS_G holds 30 cycles, NS_Y 3, EW_G 30, EW_Y 3, then back to NS_G. `phase_done` pulses at cycles 30, 33, 63, 66. `ew_light`=100 for the first 33 cycles.
- `tick` once every 4 cycles, `en` dropped for 10 cycles mid NS_G with `cnt`=12. `cnt` holds at 12 and `tick` is ignored while `en`=0; NS_G still totals 30 ticks once `en` returns.
- `flash` raised at NS_G `cnt`=5, held 6 ticks, then dropped:
  - Enters FLASH next edge; lights alternate 010/000 on each tick; `remain`=0.
  - After `flash` drops: NS_G, `cnt`=1, `remain`=30.
- `flash`=1 on the same edge as `tick` with `equal`=1 in NS_Y: FLASH is entered, not EW_G.
- `equal` tied to 0, `size`=4: after 15 ticks `cnt`=15, the next tick forces NS_Y and sets `err`=1, and `err` stays 1 through later phases.
- `rst_n` pulsed low mid EW_Y asynchronously between edges: outputs immediately return to the reset values listed under Timing.
